eth_rx: RTL and testbench
=========================

// Module: eth_rx
// PURPOSE
//  Receive pipe: parses PHY-decoded Ethernet frames (MAC+VLAN / IPv4 / UDP), filters on
//  dst MAC, dst IP, protocol and dst port, then streams UDP payload to the application.
//  Sits between the PCS decoder output and the app. FCS is stripped and not checked here.
// PARAMETERS
//  DATA_W        16                 beat width in bits; 8*HEAD_N % DATA_W != 0 is an elab error
//  KEEP_W        DATA_W/8           bytes per beat
//  LEN_W         $clog2(KEEP_W+1)   byte-count width
//  PKT_LEN_W     16                 UDP payload length width
//  VLAN_TAG      1                  1: 802.1Q tag present, HEAD_N=54; 0: HEAD_N=50
//  MAC_DST_ADDR  48'h000000FCD4F2   accepted destination MAC
//  IP_DST_ADDR   {206,200,127,128}  accepted destination IPv4
//  DST_PORT      16'd18170          accepted UDP destination port
// PORTS
//  clk             in   1          clock
//  reset           in   1          async active-high reset
//  phy_valid_i     in   1          beat valid; beats with 0 are ignored (no state change)
//  phy_start_i     in   1          beat carries frame bytes 0..KEEP_W-1
//  phy_data_i      in   DATA_W     frame bytes, first on wire in [7:0]
//  phy_term_i      in   1          last beat of frame
//  phy_term_len_i  in   LEN_W      valid bytes in term beat, 0..KEEP_W
//  app_head_v_o    out  1          1-cycle pulse: header accepted
//  app_pkt_len_o   out  PKT_LEN_W  UDP length-8, held from app_head_v_o until next accept
//  app_valid_o     out  1          payload beat valid
//  app_data_o      out  DATA_W     payload bytes, LSB-aligned
//  app_len_o       out  LEN_W      valid bytes in beat, 1..KEEP_W
//  app_last_o      out  1          final payload beat
//  app_cancel_o    out  1          1-cycle pulse: accepted frame aborted, drop partial payload
// BEHAVIOUR
//  Reset: FSM=IDLE, counters 0, all outputs 0. Everything below applies to phy_valid_i=1 beats.
//  FSM IDLE->HEAD on phy_start_i; HEAD->DATA on header accept; HEAD->DROP on any check
//   failure; DATA->DROP when payload count reaches app_pkt_len (after last); DROP->IDLE on
//   phy_term_i; HEAD/DATA->IDLE on phy_term_i (DATA: with app_cancel_o).
//  Header byte offsets (VLAN_TAG=1; subtract 4 from 24 on if 0): SFD byte 7 = 8'hD5;
//   dst MAC 8-13; TPID 20-21 = 16'h8100; ethertype 24-25 = 16'h0800; IP byte 26 = 8'h45;
//   protocol 35 = 8'd17; dst IP 42-45; dst port 48-49; UDP length 50-51. Multi-byte fields
//   big-endian. Bytes not listed are ignored. Bytes 0-6 unchecked.
//  Checks evaluated as bytes arrive; accept on beat containing byte HEAD_N-1 iff all pass
//   and UDP length > 8. UDP length <= 8 -> DROP, no app_head_v_o.
//  app_head_v_o registered: 1 cycle after the last header beat. Payload beat latency: 1 cycle
//   from input beat to app_valid_o; no backpressure (app must always sink).
//  Payload: remaining = app_pkt_len - bytes sent; app_len_o = min(KEEP_W, remaining);
//   app_last_o when remaining <= KEEP_W. Bytes after payload (padding, FCS) discarded.
//  phy_term_i in HEAD: silent drop. phy_term_i in DATA before last beat: beat's valid bytes
//   (term_len, if >0) are NOT forwarded; app_cancel_o pulses instead, no app_last_o.
//  phy_start_i while not IDLE: current frame abandoned (app_cancel_o if in DATA), restart
//   header parse on this beat. Counter overflow impossible: payload count saturates at len.
//  phy_valid_i=0 mid-frame: all state held, outputs app_valid_o/pulses deasserted.
//  Reset asserted mid-frame: immediate return to reset state; no cancel pulse.
// TESTING
//  1 Matching frame, UDP len 8+10, DATA_W=16 -> app_head_v_o with len 10; 5 beats len 2,
//    last on 5th; data equals sent payload byte-for-byte.
//  2 Odd payload 7 bytes + 4 FCS + pad to 64B -> 4 beats, final app_len_o=1, pad/FCS unseen.
//  3 dst port 16'd80 (also: wrong MAC, proto 8'd6, ethertype 16'h86DD) -> no app output.
//  4 Term at payload byte 6 of 20 -> 3 beats, then app_cancel_o pulse, no app_last_o.
//  5 phy_valid_i toggled 0/1 each cycle across test 1 -> identical output sequence,
//    gapped; start mid-DATA -> cancel pulse then new frame accepted normally.
//  6 Async reset mid-payload -> outputs 0 immediately; next clean frame received intact.

Source files
------------

// File: rtl/eth_rx.sv
// eth_rx: Ethernet/VLAN/IPv4/UDP receive filter.
// Checks the header as it streams in and forwards the UDP payload.
module eth_rx #(
  parameter int          DATA_W       = 16,
  parameter int          KEEP_W       = DATA_W / 8,
  parameter int          LEN_W        = $clog2(KEEP_W + 1),
  parameter int          PKT_LEN_W    = 16,
  parameter bit          VLAN_TAG     = 1'b1,
  parameter logic [47:0] MAC_DST_ADDR = 48'h000000FCD4F2,
  parameter logic [31:0] IP_DST_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [15:0] DST_PORT     = 16'd18170
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 phy_valid_i,
  input  logic                 phy_start_i,
  input  logic [DATA_W-1:0]    phy_data_i,
  input  logic                 phy_term_i,
  input  logic [LEN_W-1:0]     phy_term_len_i,
  output logic                 app_head_v_o,
  output logic [PKT_LEN_W-1:0] app_pkt_len_o,
  output logic                 app_valid_o,
  output logic [DATA_W-1:0]    app_data_o,
  output logic [LEN_W-1:0]     app_len_o,
  output logic                 app_last_o,
  output logic                 app_cancel_o
);

  // Without the 802.1Q tag every field from the ethertype on moves 4 bytes down.
  localparam int OFF    = VLAN_TAG ? 0 : 4;
  localparam int HEAD_N = 54 - OFF;

  // The payload must start on a beat boundary so lane 0 is payload byte 0.
  if ((8 * HEAD_N) % DATA_W != 0) begin : g_bad_width
    $error("eth_rx: header length is not a whole number of beats");
  end

  typedef enum logic [1:0] {IDLE, HEAD, DATA, DROP} state_t;

  state_t               state, state_n;
  logic [PKT_LEN_W-1:0] cnt, cnt_n;
  logic [15:0]          ulen, ulen_n;
  logic [PKT_LEN_W-1:0] pkt_len_n;
  logic                 head_n, valid_n, last_n, cancel_n;
  logic [DATA_W-1:0]    data_n;
  logic [LEN_W-1:0]     len_n;

  logic [PKT_LEN_W-1:0] base, rem;
  logic [LEN_W-1:0]     beat_len;
  logic [15:0]          ulv;
  logic                 okv, fits;
  int                   idx;

  // Returns 0 when byte i of the frame holds a value we do not accept.
  function automatic logic byte_ok(input int i, input logic [7:0] b);
    logic        ok;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;
    ok     = 1'b1;
    mac_sh = MAC_DST_ADDR >> (8 * (13 - i));
    ip_sh  = IP_DST_ADDR >> (8 * (45 - OFF - i));
    unique case (1'b1)
      (i == 7):                          ok = (b == 8'hD5);
      (i >= 8 && i <= 13):               ok = (b == mac_sh[7:0]);
      (VLAN_TAG && i == 20):             ok = (b == 8'h81);
      (VLAN_TAG && i == 21):             ok = (b == 8'h00);
      (i == 24 - OFF):                   ok = (b == 8'h08);
      (i == 25 - OFF):                   ok = (b == 8'h00);
      (i == 26 - OFF):                   ok = (b == 8'h45);
      (i == 35 - OFF):                   ok = (b == 8'd17);
      (i >= 42 - OFF && i <= 45 - OFF):  ok = (b == ip_sh[7:0]);
      (i == 48 - OFF):                   ok = (b == DST_PORT[15:8]);
      (i == 49 - OFF):                   ok = (b == DST_PORT[7:0]);
      default:                           ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Next-state, header checks and registered output values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ulen_n    = ulen;
    pkt_len_n = app_pkt_len_o;
    head_n    = 1'b0;
    valid_n   = 1'b0;
    data_n    = app_data_o;
    len_n     = '0;
    last_n    = 1'b0;
    cancel_n  = 1'b0;
    base      = cnt;
    okv       = 1'b1;
    ulv       = ulen;
    idx       = 0;
    rem       = app_pkt_len_o - cnt;
    fits      = (rem <= PKT_LEN_W'(KEEP_W));
    beat_len  = fits ? LEN_W'(rem) : LEN_W'(KEEP_W);
    if (phy_valid_i) begin
      if (phy_start_i || state == HEAD) begin
        if (phy_start_i) begin
          base     = '0;
          ulv      = '0;
          cancel_n = (state == DATA);
        end
        for (int k = 0; k < KEEP_W; k++) begin
          idx = int'(base) + k;
          if (!byte_ok(idx, phy_data_i[8*k +: 8])) okv = 1'b0;
          if (idx == 50 - OFF) ulv[15:8] = phy_data_i[8*k +: 8];
          if (idx == 51 - OFF) ulv[7:0]  = phy_data_i[8*k +: 8];
        end
        if (phy_term_i) begin
          state_n = IDLE;
        end else if (!okv) begin
          state_n = DROP;
        end else if (int'(base) + KEEP_W >= HEAD_N) begin
          if (ulv > 16'd8) begin
            state_n   = DATA;
            head_n    = 1'b1;
            pkt_len_n = PKT_LEN_W'(ulv - 16'd8);
            cnt_n     = '0;
          end else begin
            state_n = DROP;
          end
        end else begin
          state_n = HEAD;
          cnt_n   = base + PKT_LEN_W'(KEEP_W);
          ulen_n  = ulv;
        end
      end else if (state == DATA) begin
        // A short term beat that cannot finish the payload aborts it.
        if (phy_term_i &&
            !(fits && PKT_LEN_W'(phy_term_len_i) >= rem)) begin
          cancel_n = 1'b1;
          state_n  = IDLE;
        end else begin
          valid_n = 1'b1;
          data_n  = phy_data_i;
          len_n   = beat_len;
          last_n  = fits;
          cnt_n   = cnt + PKT_LEN_W'(beat_len);
          if (fits) state_n = phy_term_i ? IDLE : DROP;
        end
      end else if (state == DROP && phy_term_i) begin
        state_n = IDLE;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      ulen          <= '0;
      app_head_v_o  <= 1'b0;
      app_pkt_len_o <= '0;
      app_valid_o   <= 1'b0;
      app_data_o    <= '0;
      app_len_o     <= '0;
      app_last_o    <= 1'b0;
      app_cancel_o  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ulen          <= ulen_n;
      app_head_v_o  <= head_n;
      app_pkt_len_o <= pkt_len_n;
      app_valid_o   <= valid_n;
      app_data_o    <= data_n;
      app_len_o     <= len_n;
      app_last_o    <= last_n;
      app_cancel_o  <= cancel_n;
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: table vectors, corner sequences and random frames
// checked against a byte-level model of the receive filter.
module tb_eth_rx;
  localparam int HEAD_N = 54;
  localparam logic [47:0] MAC  = 48'h000000FCD4F2;
  localparam logic [31:0] IP   = {8'd206, 8'd200, 8'd127, 8'd128};
  localparam logic [15:0] PORT = 16'd18170;

  logic        clk = 1'b0;
  logic        reset;
  logic        phy_valid_i, phy_start_i, phy_term_i;
  logic [15:0] phy_data_i;
  logic [1:0]  phy_term_len_i;
  logic        app_head_v_o, app_valid_o, app_last_o, app_cancel_o;
  logic [15:0] app_pkt_len_o, app_data_o;
  logic [1:0]  app_len_o;

  eth_rx dut (
    .clk(clk), .reset(reset),
    .phy_valid_i(phy_valid_i), .phy_start_i(phy_start_i),
    .phy_data_i(phy_data_i), .phy_term_i(phy_term_i),
    .phy_term_len_i(phy_term_len_i),
    .app_head_v_o(app_head_v_o), .app_pkt_len_o(app_pkt_len_o),
    .app_valid_o(app_valid_o), .app_data_o(app_data_o),
    .app_len_o(app_len_o), .app_last_o(app_last_o),
    .app_cancel_o(app_cancel_o)
  );

  always #5 clk = ~clk;

  // kind: 0 header, 1 payload beat, 2 cancel
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
    logic [15:0] data;
    logic [1:0]  len;
    logic        last;
  } evt_t;

  typedef struct {
    logic [47:0] mac;
    logic [15:0] et;
    logic [7:0]  pr;
    logic [31:0] ip;
    logic [15:0] port;
    int          plen;
    logic [15:0] ulen;
    int          trunc;
    int          e_head;
    int          e_beats;
    int          e_cancel;
    int          e_lastlen;
    string       name;
  } vec_t;

  evt_t       obs[$];
  evt_t       expq[$];
  logic [7:0] fr[$];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (app_head_v_o)
        obs.push_back('{2'd0, app_pkt_len_o, 16'h0, 2'd0, 1'b0});
      if (app_valid_o)
        obs.push_back('{2'd1, 16'h0,
          (app_len_o == 2'd1) ? {8'h00, app_data_o[7:0]} : app_data_o,
          app_len_o, app_last_o});
      if (app_cancel_o)
        obs.push_back('{2'd2, 16'h0, 16'h0, 2'd0, 1'b0});
    end
  end

  function automatic logic [7:0] fb(input int i);
    return (i < fr.size()) ? fr[i] : 8'h00;
  endfunction

  task automatic build(input logic [47:0] mac, input logic [15:0] et,
                       input logic [7:0] pr, input logic [31:0] ip,
                       input logic [15:0] port, input int plen,
                       input logic [15:0] ulen, input int trunc);
    fr.delete();
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(mac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    fr.push_back(8'h81); fr.push_back(8'h00);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    fr.push_back(et[15:8]); fr.push_back(et[7:0]);
    fr.push_back(8'h45);
    for (int i = 0; i < 8; i++) fr.push_back(8'($urandom));
    fr.push_back(pr);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) fr.push_back(ip[8*(3-i) +: 8]);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    fr.push_back(port[15:8]); fr.push_back(port[7:0]);
    fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
    while (fr.size() < 60) fr.push_back(8'h00);
    for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
    if (trunc > 0)
      while (fr.size() > trunc) void'(fr.pop_back());
  endtask

  // Expected output events for the frame in fr. Without a term beat the
  // frame is cut short by the next start beat.
  task automatic model(input bit term_en);
    int f, nb, t, l, p;
    bit ok, done;
    logic [15:0] ul;
    f  = fr.size();
    nb = (f + 1) / 2;
    t  = term_en ? nb - 1 : nb;
    ok = (t >= HEAD_N / 2) && fb(7) == 8'hD5;
    for (int i = 0; i < 6; i++) if (fb(8 + i) != MAC[8*(5-i) +: 8]) ok = 0;
    if (fb(20) != 8'h81 || fb(21) != 8'h00) ok = 0;
    if (fb(24) != 8'h08 || fb(25) != 8'h00) ok = 0;
    if (fb(26) != 8'h45 || fb(35) != 8'd17) ok = 0;
    for (int i = 0; i < 4; i++) if (fb(42 + i) != IP[8*(3-i) +: 8]) ok = 0;
    if ({fb(48), fb(49)} != PORT) ok = 0;
    ul = {fb(50), fb(51)};
    if (ul <= 16'd8) ok = 0;
    if (!ok) return;
    l = int'(ul) - 8;
    expq.push_back('{2'd0, 16'(l), 16'h0, 2'd0, 1'b0});
    done = 0;
    for (int j = HEAD_N / 2; j <= t && !done; j++) begin
      p = 2 * (j - HEAD_N / 2);
      if (j == t && !(term_en && f - HEAD_N >= l)) break;
      if (l - p <= 2) done = 1;
      expq.push_back('{2'd1, 16'h0,
        (l - p == 1) ? {8'h00, fb(HEAD_N + p)}
                     : {fb(HEAD_N + p + 1), fb(HEAD_N + p)},
        (l - p >= 2) ? 2'd2 : 2'd1, done});
    end
    if (!done) expq.push_back('{2'd2, 16'h0, 16'h0, 2'd0, 1'b0});
  endtask

  task automatic send(input bit gap, input bit term_en, input int maxb);
    int nb, n;
    nb = (fr.size() + 1) / 2;
    n  = (maxb < 0) ? nb : maxb;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      phy_valid_i    = 1'b1;
      phy_start_i    = (j == 0);
      phy_data_i     = {(2*j+1 < fr.size()) ? fr[2*j+1] : 8'($urandom),
                        fr[2*j]};
      phy_term_i     = term_en && (j == nb - 1);
      phy_term_len_i = phy_term_i ? 2'(fr.size() - 2*j) : 2'd0;
      if (gap) begin
        @(posedge clk); #1;
        phy_valid_i    = 1'b0;
        phy_start_i    = 1'($urandom);
        phy_data_i     = 16'($urandom);
        phy_term_i     = 1'($urandom);
        phy_term_len_i = 2'($urandom);
      end
    end
    @(posedge clk); #1;
    phy_valid_i = 1'b0;
    phy_start_i = 1'b0;
    phy_term_i  = 1'b0;
  endtask

  task automatic compare(input string name);
    int n;
    repeat (4) @(posedge clk);
    #1;
    check({name, "_count"}, obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) check(name, obs[i], expq[i]);
    obs.delete();
    expq.delete();
  endtask

  task automatic tally(output int h, output int b, output int c,
                       output int ll);
    h = 0; b = 0; c = 0; ll = 0;
    foreach (obs[i]) begin
      if (obs[i].kind == 2'd0) h++;
      if (obs[i].kind == 2'd1) begin b++; ll = int'(obs[i].len); end
      if (obs[i].kind == 2'd2) c++;
    end
  endtask

  vec_t tbl[11];

  initial begin
    int h, b, c, ll, plen, tr;
    logic [15:0] ul;
    bit gap;
    tbl[0]  = '{MAC, 16'h0800, 8'd17, IP, PORT, 10, 16'd18, 0, 1, 5, 0, 2, "good10"};
    tbl[1]  = '{MAC, 16'h0800, 8'd17, IP, PORT, 7, 16'd15, 0, 1, 4, 0, 1, "odd7"};
    tbl[2]  = '{MAC, 16'h0800, 8'd17, IP, 16'd80, 10, 16'd18, 0, 0, 0, 0, 0, "port80"};
    tbl[3]  = '{48'h000000FCD4F3, 16'h0800, 8'd17, IP, PORT, 10, 16'd18, 0, 0, 0, 0, 0, "badmac"};
    tbl[4]  = '{MAC, 16'h0800, 8'd6, IP, PORT, 10, 16'd18, 0, 0, 0, 0, 0, "tcp"};
    tbl[5]  = '{MAC, 16'h86DD, 8'd17, IP, PORT, 10, 16'd18, 0, 0, 0, 0, 0, "ipv6"};
    tbl[6]  = '{MAC, 16'h0800, 8'd17, IP, PORT, 20, 16'd28, 62, 1, 3, 1, 2, "trunc"};
    tbl[7]  = '{MAC, 16'h0800, 8'd17, IP, PORT, 0, 16'd8, 0, 0, 0, 0, 0, "ulen8"};
    tbl[8]  = '{MAC, 16'h0800, 8'd17, 32'hCEC87F81, PORT, 10, 16'd18, 0, 0, 0, 0, 0, "badip"};
    tbl[9]  = '{MAC, 16'h0800, 8'd17, IP, PORT, 10, 16'd18, 40, 0, 0, 0, 0, "termhdr"};
    tbl[10] = '{MAC, 16'h0800, 8'd17, IP, PORT, 1, 16'd9, 0, 1, 1, 0, 1, "ulen9"};

    reset = 1'b1;
    phy_valid_i = 0; phy_start_i = 0; phy_term_i = 0;
    phy_data_i = '0; phy_term_len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {app_head_v_o, app_pkt_len_o, app_valid_o,
          app_data_o, app_len_o, app_last_o, app_cancel_o}, '0);
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      build(tbl[v].mac, tbl[v].et, tbl[v].pr, tbl[v].ip, tbl[v].port,
            tbl[v].plen, tbl[v].ulen, tbl[v].trunc);
      model(1'b1);
      send(1'b0, 1'b1, -1);
      repeat (4) @(posedge clk);
      tally(h, b, c, ll);
      check({tbl[v].name, "_heads"}, h, tbl[v].e_head);
      check({tbl[v].name, "_beats"}, b, tbl[v].e_beats);
      check({tbl[v].name, "_cancels"}, c, tbl[v].e_cancel);
      check({tbl[v].name, "_lastlen"}, ll, tbl[v].e_lastlen);
      compare(tbl[v].name);
    end

    build(MAC, 16'h0800, 8'd17, IP, PORT, 10, 16'd18, 0);
    model(1'b1);
    send(1'b1, 1'b1, -1);
    compare("gapped");

    build(MAC, 16'h0800, 8'd17, IP, PORT, 20, 16'd28, 60);
    model(1'b0);
    send(1'b0, 1'b0, -1);
    build(MAC, 16'h0800, 8'd17, IP, PORT, 10, 16'd18, 0);
    model(1'b1);
    send(1'b0, 1'b1, -1);
    compare("restart");

    build(MAC, 16'h0800, 8'd17, IP, PORT, 20, 16'd28, 0);
    send(1'b0, 1'b0, 30);
    check("pre_rst_valid", app_valid_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_outs", {app_head_v_o, app_pkt_len_o, app_valid_o,
          app_data_o, app_len_o, app_last_o, app_cancel_o}, '0);
    @(negedge clk);
    obs.delete();
    reset = 1'b0;
    build(MAC, 16'h0800, 8'd17, IP, PORT, 12, 16'd20, 0);
    model(1'b1);
    send(1'b0, 1'b1, -1);
    compare("post_rst");

    for (int r = 0; r < 40; r++) begin
      plen = $urandom_range(1, 40);
      ul   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 8))
                                         : 16'(plen + 8);
      tr   = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 100) : 0;
      gap  = 1'($urandom);
      build(($urandom_range(0, 7) == 0) ? 48'($urandom) : MAC,
            ($urandom_range(0, 7) == 0) ? 16'h86DD : 16'h0800,
            ($urandom_range(0, 7) == 0) ? 8'd6 : 8'd17,
            ($urandom_range(0, 7) == 0) ? 32'($urandom) : IP,
            ($urandom_range(0, 7) == 0) ? 16'($urandom) : PORT,
            plen, ul, tr);
      model(1'b1);
      send(gap, 1'b1, -1);
      compare("random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
